// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC sin/cos pipeline: arctan table, gain and pi in Q2.30,
// plus helpers that rescale them to the pipeline's fractional width (FRAC <= 30).
package cordic_pkg;

  localparam longint K_Q30  = 64'h0000_0000_26DD_3B6A;
  localparam longint PI_Q30 = 64'h0000_0000_C90F_DAA2;

  // Sideband that travels alongside x/y/z through every stage.
  typedef struct packed {
    logic valid;
    logic neg;
    logic n;
    logic err;
  } side_t;

  // arctan(2^-i) in Q2.30, truncated.
  function automatic logic [31:0] atan_q30(input int i);
    logic [31:0] v;
    case (i)
      0:  v = 32'h3243F6A8;  1:  v = 32'h1DAC6705;  2:  v = 32'h0FADBAFC;  3:  v = 32'h07F56EA6;
      4:  v = 32'h03FEAB76;  5:  v = 32'h01FFD55B;  6:  v = 32'h00FFFAAA;  7:  v = 32'h007FFF55;
      8:  v = 32'h003FFFEA;  9:  v = 32'h001FFFFD;  10: v = 32'h000FFFFF;  11: v = 32'h0007FFFF;
      12: v = 32'h0003FFFF;  13: v = 32'h0001FFFF;  14: v = 32'h0000FFFF;  15: v = 32'h00007FFF;
      16: v = 32'h00003FFF;  17: v = 32'h00001FFF;  18: v = 32'h00000FFF;  19: v = 32'h000007FF;
      20: v = 32'h000003FF;  21: v = 32'h000001FF;  22: v = 32'h000000FF;  23: v = 32'h0000007F;
      24: v = 32'h0000003F;  25: v = 32'h0000001F;  26: v = 32'h0000000F;  27: v = 32'h00000008;
      28: v = 32'h00000004;  29: v = 32'h00000002;  30: v = 32'h00000001;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  function automatic longint scale_q30(input longint v, input int frac);
    return v >>> (30 - frac);
  endfunction

  function automatic longint atan_at(input int i, input int frac);
    return scale_q30(longint'(atan_q30(i)), frac);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; sideband is carried unchanged.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int                       WIDTH = 32,
  parameter int                       SHIFT = 0,
  parameter logic signed [WIDTH-1:0]  ATAN  = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  side_t                    side,
  input  logic signed [WIDTH-1:0]  x,
  input  logic signed [WIDTH-1:0]  y,
  input  logic signed [WIDTH-1:0]  z,
  output side_t                    rot_side,
  output logic signed [WIDTH-1:0]  rot_x,
  output logic signed [WIDTH-1:0]  rot_y,
  output logic signed [WIDTH-1:0]  rot_z
);

  logic                    dir;
  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;

  // Rotate toward zero residual angle: positive z rotates counter-clockwise.
  assign dir  = ~z[WIDTH-1];
  assign x_sh = x >>> SHIFT;
  assign y_sh = y >>> SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rot_side <= '0;
      rot_x    <= '0;
      rot_y    <= '0;
      rot_z    <= '0;
    end else if (clk_en) begin
      rot_side <= side;
      rot_x    <= dir ? x - y_sh : x + y_sh;
      rot_y    <= dir ? y + x_sh : y - x_sh;
      rot_z    <= dir ? z - ATAN : z + ATAN;
    end
  end

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Fully pipelined CORDIC cos/sin over [-pi, +pi] behind a custom-instruction style port.
// Fold stage -> ITERATIONS micro-rotations -> registered output; clk_en stalls everything.
module cordic_sincos_pipe
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 29,
  parameter int ITERATIONS = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic             n,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out,
  output logic             done,
  output logic             range_err
);

  localparam logic signed [WIDTH-1:0] PI      = WIDTH'(scale_q30(PI_Q30, FRAC));
  localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(scale_q30(PI_Q30, FRAC) >>> 1);
  localparam logic signed [WIDTH-1:0] K       = WIDTH'(scale_q30(K_Q30, FRAC));

  logic signed [WIDTH-1:0] angle;
  logic signed [WIDTH-1:0] fold_z;
  logic                    fold_neg;
  logic                    fold_err;

  assign angle = dataa;

  // Outer quadrants map onto [-pi/2, pi/2] by a pi shift, which negates both outputs.
  always_comb begin
    fold_z   = angle;
    fold_neg = 1'b0;
    fold_err = 1'b0;
    if (angle > PI || angle < -PI) begin
      fold_z   = '0;
      fold_err = 1'b1;
    end else if (angle > HALF_PI) begin
      fold_z   = angle - PI;
      fold_neg = 1'b1;
    end else if (angle < -HALF_PI) begin
      fold_z   = angle + PI;
      fold_neg = 1'b1;
    end
  end

  side_t                   s0_side;
  logic signed [WIDTH-1:0] s0_x;
  logic signed [WIDTH-1:0] s0_y;
  logic signed [WIDTH-1:0] s0_z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_side <= '0;
      s0_x    <= '0;
      s0_y    <= '0;
      s0_z    <= '0;
    end else if (clk_en) begin
      s0_side <= '{valid: start, neg: fold_neg, n: n, err: fold_err};
      s0_x    <= K;
      s0_y    <= '0;
      s0_z    <= fold_z;
    end
  end

  side_t                   side_p [ITERATIONS+1];
  logic signed [WIDTH-1:0] x_p    [ITERATIONS+1];
  logic signed [WIDTH-1:0] y_p    [ITERATIONS+1];
  logic signed [WIDTH-1:0] z_p    [ITERATIONS+1];

  assign side_p[0] = s0_side;
  assign x_p[0]    = s0_x;
  assign y_p[0]    = s0_y;
  assign z_p[0]    = s0_z;

  for (genvar i = 0; i < ITERATIONS; i++) begin : g_stage
    cordic_stage #(
      .WIDTH (WIDTH),
      .SHIFT (i),
      .ATAN  (WIDTH'(atan_at(i, FRAC)))
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clk_en   (clk_en),
      .side     (side_p[i]),
      .x        (x_p[i]),
      .y        (y_p[i]),
      .z        (z_p[i]),
      .rot_side (side_p[i+1]),
      .rot_x    (x_p[i+1]),
      .rot_y    (y_p[i+1]),
      .rot_z    (z_p[i+1])
    );
  end

  side_t                   last;
  logic signed [WIDTH-1:0] cos_v;
  logic signed [WIDTH-1:0] sin_v;

  assign last = side_p[ITERATIONS];

  always_comb begin
    cos_v = last.neg ? -x_p[ITERATIONS] : x_p[ITERATIONS];
    sin_v = last.neg ? -y_p[ITERATIONS] : y_p[ITERATIONS];
  end

  // Data outputs change only on a retiring angle; done/range_err are one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      range_err <= 1'b0;
      result    <= '0;
      cos_out   <= '0;
      sin_out   <= '0;
    end else if (clk_en) begin
      done      <= last.valid;
      range_err <= last.valid & last.err;
      if (last.valid) begin
        if (last.err) begin
          result  <= '0;
          cos_out <= '0;
          sin_out <= '0;
        end else begin
          result  <= last.n ? sin_v : cos_v;
          cos_out <= cos_v;
          sin_out <= sin_v;
        end
      end
    end
  end

endmodule
